// File: rtl/dmem_arbiter.sv
// Two-port weighted round-robin arbiter in front of a single-port word-addressed data memory.
// Optional misaligned-access trapping is enabled with `define DMEM_ARB_MISALIGN_ERR_EN.
module dmem_arbiter #(
  parameter int unsigned CoreWeight = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 p0_req_valid_i,
  output logic                 p0_req_ready_o,
  input  logic                 p0_we_i,
  input  logic [AddrWidth-1:0] p0_addr_i,
  input  logic [DataWidth-1:0] p0_wdata_i,
  output logic                 p0_rsp_valid_o,
  input  logic                 p0_rsp_ready_i,
  output logic [DataWidth-1:0] p0_rdata_o,
  output logic                 p0_rsp_err_o,

  input  logic                 p1_req_valid_i,
  output logic                 p1_req_ready_o,
  input  logic                 p1_we_i,
  input  logic [AddrWidth-1:0] p1_addr_i,
  input  logic [DataWidth-1:0] p1_wdata_i,
  output logic                 p1_rsp_valid_o,
  input  logic                 p1_rsp_ready_i,
  output logic [DataWidth-1:0] p1_rdata_o,
  output logic                 p1_rsp_err_o,

  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_a_o,
  output logic [DataWidth-1:0] mem_wd_o,
  input  logic [DataWidth-1:0] mem_rd_i
);

  localparam logic [3:0] Weight = 4'(CoreWeight);

  logic                 elig0, elig1, contested, gnt0, gnt1, gnt_any;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 sel_we;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 fwd;

  logic                 rsp_valid0_q, rsp_valid0_d, rsp_valid1_q, rsp_valid1_d;
  logic [DataWidth-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;

  // A port whose response is being consumed this cycle can take a new request.
  assign elig0     = p0_req_valid_i & (~rsp_valid0_q | p0_rsp_ready_i);
  assign elig1     = p1_req_valid_i & (~rsp_valid1_q | p1_rsp_ready_i);
  assign contested = elig0 & elig1;

  // Grants are gated by reset so nothing is accepted or written while reset is low.
  assign gnt0    = rst_ni & elig0 & (~elig1 | (wcnt_q < Weight));
  assign gnt1    = rst_ni & elig1 & ~gnt0;
  assign gnt_any = gnt0 | gnt1;

  assign p0_req_ready_o = gnt0;
  assign p1_req_ready_o = gnt1;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt0) begin
      sel_we    = p0_we_i;
      sel_addr  = p0_addr_i;
      sel_wdata = p0_wdata_i;
    end else if (gnt1) begin
      sel_we    = p1_we_i;
      sel_addr  = p1_addr_i;
      sel_wdata = p1_wdata_i;
    end
  end

`ifdef DMEM_ARB_MISALIGN_ERR_EN
  logic sel_mis;
  assign sel_mis = sel_addr[1:0] != 2'b00;
  assign fwd     = gnt_any & ~sel_mis;
  assign rsp_err = sel_mis;
`else
  assign fwd     = gnt_any;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    mem_we_o = 1'b0;
    mem_a_o  = '0;
    mem_wd_o = '0;
    if (fwd) begin
      mem_we_o = sel_we;
      mem_a_o  = sel_addr;
      mem_wd_o = sel_wdata;
    end
  end

  // Writes and trapped accesses return zero data.
  assign rsp_rdata = (fwd && !sel_we) ? mem_rd_i : '0;

  always_comb begin
    wcnt_d = wcnt_q;
    if (gnt1) begin
      wcnt_d = 4'd0;
    end else if (gnt0 && contested) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  always_comb begin
    rsp_valid0_d = rsp_valid0_q;
    rdata0_d     = rdata0_q;
    err0_d       = err0_q;
    if (gnt0) begin
      rsp_valid0_d = 1'b1;
      rdata0_d     = rsp_rdata;
      err0_d       = rsp_err;
    end else if (p0_rsp_ready_i) begin
      rsp_valid0_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid1_d = rsp_valid1_q;
    rdata1_d     = rdata1_q;
    err1_d       = err1_q;
    if (gnt1) begin
      rsp_valid1_d = 1'b1;
      rdata1_d     = rsp_rdata;
      err1_d       = rsp_err;
    end else if (p1_rsp_ready_i) begin
      rsp_valid1_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q       <= 4'd0;
      rsp_valid0_q <= 1'b0;
      rdata0_q     <= '0;
      err0_q       <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rdata1_q     <= '0;
      err1_q       <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      rsp_valid0_q <= rsp_valid0_d;
      rdata0_q     <= rdata0_d;
      err0_q       <= err0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rdata1_q     <= rdata1_d;
      err1_q       <= err1_d;
    end
  end

  assign p0_rsp_valid_o = rsp_valid0_q;
  assign p0_rdata_o     = rdata0_q;
  assign p0_rsp_err_o   = err0_q;
  assign p1_rsp_valid_o = rsp_valid1_q;
  assign p1_rdata_o     = rdata1_q;
  assign p1_rsp_err_o   = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  bit [31:0] mem [256];

  always #5 clk = ~clk;

  // Memory ignores misaligned writes and returns zero for misaligned reads.
  assign mem_rd = (mem_a[1:0] == 2'b00) ? mem[mem_a[9:2]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_a[1:0] == 2'b00) mem[mem_a[9:2]] <= mem_wd;

  dmem_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .p0_req_valid_i (p0_req_valid),
    .p0_req_ready_o (p0_req_ready),
    .p0_we_i        (p0_we),
    .p0_addr_i      (p0_addr),
    .p0_wdata_i     (p0_wdata),
    .p0_rsp_valid_o (p0_rsp_valid),
    .p0_rsp_ready_i (p0_rsp_ready),
    .p0_rdata_o     (p0_rdata),
    .p0_rsp_err_o   (p0_rsp_err),
    .p1_req_valid_i (p1_req_valid),
    .p1_req_ready_o (p1_req_ready),
    .p1_we_i        (p1_we),
    .p1_addr_i      (p1_addr),
    .p1_wdata_i     (p1_wdata),
    .p1_rsp_valid_o (p1_rsp_valid),
    .p1_rsp_ready_i (p1_rsp_ready),
    .p1_rdata_o     (p1_rdata),
    .p1_rsp_err_o   (p1_rsp_err),
    .mem_we_o       (mem_we),
    .mem_a_o        (mem_a),
    .mem_wd_o       (mem_wd),
    .mem_rd_i       (mem_rd)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic test_reset();
    p0_req_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h1111;
    p1_req_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h44; p1_wdata = 32'h2222;
    #2;
    checks++;
    if ({p0_req_ready, p1_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {p0_req_ready, p1_req_ready});
    end
    repeat (2) cyc();
    checks++;
    if ({mem_we, mem_a, mem_wd} !== 65'h0) begin
      errors++; $display("FAIL reset_mem: got we=%b a=%h wd=%h expected 0", mem_we, mem_a, mem_wd);
    end
    checks++;
    if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, p0_rdata, p1_rdata} !== 68'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b%b d=%h/%h expected 0", p0_rsp_valid,
                         p1_rsp_valid, p0_rdata, p1_rdata);
    end
    idle();
    @(negedge clk) rst_ni = 1'b1;
    cyc();
    checks++;
    if (mem[16] !== 32'h0 || mem[17] !== 32'h0) begin
      errors++; $display("FAIL reset_no_write: got %h/%h expected 0", mem[16], mem[17]);
    end
  endtask

  task automatic test_single_write_read();
    p0_rsp_ready = 1'b1;
    p0_req_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({p0_req_ready, mem_we, mem_a, mem_wd} !== {2'b11, 32'h10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_accept: got rdy=%b we=%b a=%h wd=%h expected 1 1 10 deadbeef",
                         p0_req_ready, mem_we, mem_a, mem_wd);
    end
    cyc();
    p0_we = 1'b0; p0_wdata = '0;
    #1;
    checks++;
    if ({p0_rsp_valid, p0_rsp_err, p0_rdata, p0_req_ready, mem_we} !== {2'b10, 32'h0, 2'b10}) begin
      errors++; $display("FAIL wr_rsp: got v=%b e=%b d=%h rdy=%b we=%b expected 1 0 0 1 0",
                         p0_rsp_valid, p0_rsp_err, p0_rdata, p0_req_ready, mem_we);
    end
    cyc();
    p0_req_valid = 1'b0;
    #1;
    checks++;
    if ({p0_rsp_valid, p0_rsp_err, p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_rsp: got v=%b e=%b d=%h expected 1 0 deadbeef",
                         p0_rsp_valid, p0_rsp_err, p0_rdata);
    end
    cyc();
    checks++;
    if (p0_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_clear: got %b expected 0", p0_rsp_valid);
    end
    idle();
  endtask

  task automatic test_contention();
    int gap;
    logic exp0;
    gap = 0;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    p0_req_valid = 1'b1; p0_addr = 32'h10;
    p1_req_valid = 1'b1; p1_addr = 32'h20;
    for (int i = 0; i < 15; i++) begin
      #1;
      exp0 = (i % 5) != 4;
      gap = p1_req_ready ? 0 : gap + 1;
      checks++;
      if ({p0_req_ready, p1_req_ready} !== {exp0, ~exp0} || gap > 4) begin
        errors++; $display("FAIL contention[%0d]: got %b%b gap=%0d expected %b%b", i,
                           p0_req_ready, p1_req_ready, gap, exp0, ~exp0);
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_backpressure();
    p1_rsp_ready = 1'b1; p0_rsp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hCAFEF00D;
    cyc();
    p1_we = 1'b0; p1_wdata = '0;
    #1;
    checks++;
    if (p1_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first_read: got %b expected 1", p1_req_ready);
    end
    cyc();
    p1_rsp_ready = 1'b0; p1_addr = 32'h24;
    p0_req_valid = 1'b1; p0_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({p1_req_ready, p1_rsp_valid, p1_rdata, p0_req_ready} !== {2'b01, 32'hCAFEF00D, 1'b1})
      begin
        errors++; $display("FAIL bp_stall[%0d]: got rdy1=%b v1=%b d1=%h rdy0=%b expected 0 1 cafef00d 1",
                           i, p1_req_ready, p1_rsp_valid, p1_rdata, p0_req_ready);
      end
      cyc();
    end
    p0_req_valid = 1'b0; p1_rsp_ready = 1'b1;
    #1;
    checks++;
    if (p1_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got %b expected 1", p1_req_ready);
    end
    cyc();
    p1_req_valid = 1'b0;
    #1;
    checks++;
    if ({p1_rsp_valid, p1_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL bp_new_rsp: got v=%b d=%h expected 1 0", p1_rsp_valid, p1_rdata);
    end
    idle();
    cyc();
  endtask

  task automatic test_misaligned();
    p0_rsp_ready = 1'b1;
`ifdef DMEM_ARB_MISALIGN_ERR_EN
    p0_req_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h13; p0_wdata = 32'h12345678;
    #1;
    checks++;
    if ({p0_req_ready, mem_we, mem_a} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL mis_fwd: got rdy=%b we=%b a=%h expected 1 0 0",
                         p0_req_ready, mem_we, mem_a);
    end
    cyc();
    p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = '0;
    #1;
    checks++;
    if ({p0_rsp_valid, p0_rsp_err, p0_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL mis_rsp: got v=%b e=%b d=%h expected 1 1 0",
                         p0_rsp_valid, p0_rsp_err, p0_rdata);
    end
    cyc();
    p0_req_valid = 1'b0;
    #1;
    checks++;
    if ({p0_rsp_err, p0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL mis_old_val: got e=%b d=%h expected 0 deadbeef", p0_rsp_err, p0_rdata);
    end
`else
    p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h13;
    #1;
    checks++;
    if ({p0_req_ready, mem_we, mem_a} !== {2'b10, 32'h13}) begin
      errors++; $display("FAIL mis_fwd: got rdy=%b we=%b a=%h expected 1 0 13",
                         p0_req_ready, mem_we, mem_a);
    end
    cyc();
    p0_req_valid = 1'b0;
    #1;
    checks++;
    if ({p0_rsp_valid, p0_rsp_err, p0_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL mis_rsp: got v=%b e=%b d=%h expected 1 0 0",
                         p0_rsp_valid, p0_rsp_err, p0_rdata);
    end
`endif
    idle();
    cyc();
  endtask

  task automatic test_reset_mid();
    p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b1;
    p0_req_valid = 1'b1; p0_addr = 32'h20;
    #1;
    checks++;
    if (p0_req_ready !== 1'b1) begin
      errors++; $display("FAIL rm_accept: got %b expected 1", p0_req_ready);
    end
    cyc();
    p0_addr = 32'h10;
    p1_req_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h30; p1_wdata = 32'h55;
    #1;
    checks++;
    if ({p0_rsp_valid, p0_rdata, p0_req_ready, p1_req_ready, mem_we} !==
        {1'b1, 32'hCAFEF00D, 3'b011}) begin
      errors++; $display("FAIL rm_pending: got v0=%b d0=%h rdy=%b%b we=%b expected 1 cafef00d 01 1",
                         p0_rsp_valid, p0_rdata, p0_req_ready, p1_req_ready, mem_we);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p0_rdata, mem_we, mem_a} !== 68'h0) begin
      errors++; $display("FAIL rm_outputs: got rdy=%b%b v0=%b d0=%h we=%b a=%h expected 0",
                         p0_req_ready, p1_req_ready, p0_rsp_valid, p0_rdata, mem_we, mem_a);
    end
    cyc();
    checks++;
    if (mem[12] !== 32'h0) begin
      errors++; $display("FAIL rm_no_write: got %h expected 0", mem[12]);
    end
    p1_we = 1'b0; p1_wdata = '0; p0_rsp_ready = 1'b1;
    @(negedge clk) rst_ni = 1'b1;
    #1;
    checks++;
    if ({p0_req_ready, p1_req_ready, p0_rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL rm_first_grant: got rdy=%b%b v0=%b expected 10 0",
                         p0_req_ready, p1_req_ready, p0_rsp_valid);
    end
    cyc();
    checks++;
    if ({p0_rsp_valid, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rm_new_rsp: got v=%b d=%h expected 1 deadbeef", p0_rsp_valid, p0_rdata);
    end
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if ({p0_req_ready, p1_req_ready} !== ((j < 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rm_weight[%0d]: got %b%b expected %s", j, p0_req_ready,
                           p1_req_ready, (j < 4) ? "10" : "01");
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  initial begin
    rst_ni = 1'b0;
    p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
    idle();
    test_reset();
    test_single_write_read();
    test_contention();
    test_backpressure();
    test_misaligned();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port, word-addressed data memory. It shares the memory between the core load/store path (port 0) and a DMA/debug path (port 1). Each requester gets a valid/ready request channel and a registered response channel. Contested cycles are resolved by weighted round-robin that favours the core but bounds DMA starvation.

## Interface
- CORE_WEIGHT, 4: maximum consecutive contested grants to port 0 before port 1 is forced a grant; legal range 1–15.
- AW, 32: byte-address width.
- DW, 32: data width; fixed at 32.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- P0_REQ_VALID / P1_REQ_VALID  in  1  request present.
- P0_REQ_READY / P1_REQ_READY  out  1  request accepted this cycle.
- P0_WE / P1_WE  in  1  1 = write, 0 = read.
- P0_ADDR / P1_ADDR  in  AW  byte address.
- P0_WDATA / P1_WDATA  in  DW  write data.
- P0_RSP_VALID / P1_RSP_VALID  out  1  response available.
- P0_RSP_READY / P1_RSP_READY  in  1  response consumed.
- P0_RDATA / P1_RDATA  out  DW  read data; 0 for writes.
- P0_RSP_ERR / P1_RSP_ERR  out  1  misaligned-access error.
- MEM_WE  out  1  memory write enable.
- MEM_A  out  AW  memory byte address.
- MEM_WD  out  DW  memory write data.
- MEM_RD  in  DW  memory read data; combinational from MEM_A.

## Operation
- **Eligibility.** Port i is eligible when Pi_REQ_VALID=1 and its response slot is free. The slot is free when Pi_RSP_VALID=0, or when Pi_RSP_VALID=1 and Pi_RSP_READY=1 in the same cycle.
- **Grant.** At most one port is granted per cycle, combinationally. Only the granted port sees Pi_REQ_READY=1.
  - One eligible port: that port is granted.
  - Both eligible (contested): port 0 is granted if wcnt < CORE_WEIGHT, otherwise port 1.
- **Weight counter wcnt** (4-bit):
  - Increments on a contested grant to port 0.
  - Clears to 0 on any port-1 grant.
  - Holds in all other cases.
- **Memory drive.**
  - While granted: MEM_A = granted ADDR, MEM_WD = granted WDATA, MEM_WE = granted WE.
  - No grant: MEM_WE=0, MEM_A=0, MEM_WD=0.
- **Response capture** on the edge ending the accept cycle:
  - Pi_RSP_VALID is set to 1.
  - Pi_RDATA = MEM_RD for reads, 0 for writes.
  - Pi_RSP_ERR is captured as defined under Configuration.
- **Response hold.** RSP_VALID, RDATA and RSP_ERR hold until RSP_READY=1. RSP_VALID then clears, unless a new request for that port is accepted in the same cycle, in which case the new response is loaded.
- **Port independence.** A stalled port-1 response never blocks port 0, and vice versa.
- **Reset.** While RST_N=0:
  - All REQ_READY, RSP_VALID, RSP_ERR, RDATA, MEM_* outputs are 0.
  - wcnt=0.
  - Pending responses are discarded.
  - An acceptance in progress when reset asserts is dropped; no memory write occurs after RST_N falls.

## Timing
- Accept in cycle T (REQ_VALID & REQ_READY). Write commits at the T→T+1 edge. RSP_VALID=1 from T+1.
- Request-to-response latency: 1 cycle.
- Sustained throughput: 1 access/cycle total. A single port sustains 1/cycle if it holds RSP_READY=1.
- REQ_READY depends combinationally on REQ_VALID of both ports, RSP_VALID and RSP_READY. Requesters must not make REQ_VALID depend on REQ_READY.
- First cycle after RST_N rises: arbitration is active; wcnt=0.

## Configuration
- Macro: DMEM_ARB_MISALIGN_ERR_EN.
- **Defined:** a request with ADDR[1:0]≠0 is accepted normally, but:
  - it is not forwarded to memory (MEM_WE=0, MEM_A=0 that cycle);
  - its response has RSP_ERR=1 and RDATA=0;
  - it still consumes the grant and updates wcnt.
- **Undefined:** all requests are forwarded unchanged and RSP_ERR is tied to 0. The memory's own rule applies: misaligned writes are ignored and misaligned reads return 0.

## Test plan
- **Single write/read.** P0 write 0xDEADBEEF to 0x10 at T, then read 0x10 at T+1 with RSP_READY=1 → P0_RSP_VALID at T+1 and T+2; RDATA=0xDEADBEEF at T+2; RSP_ERR=0.
- **Weighted contention.** Both ports request continuously with RSP_READY=1 and CORE_WEIGHT=4 → grant pattern 0,0,0,0,1 repeating; no port-1 gap longer than 4 cycles.
- **Backpressure.** P1 read accepted, P1_RSP_READY=0 for 5 cycles with P1_REQ_VALID=1 → P1_REQ_READY=0 throughout, P1_RDATA stable, P0 requests still granted every cycle; P1 accepted again in the cycle RSP_READY rises.
- **Misaligned access, macro defined.** P0 write to 0x13 → MEM_WE=0; response RSP_ERR=1, RDATA=0; a following read of 0x10 returns its old value.
- **Misaligned access, macro undefined.** P0 read of 0x13 → RSP_ERR=0, RDATA=0.
- **Reset mid-operation.** Assert RST_N low with P0 response pending and P1 request valid → all outputs 0 immediately; after release, first contested cycle grants port 0 with wcnt=0; the pre-reset response never appears.
